iob_ptfloat_pack: RTL
=====================

// Module: iob_ptfloat_pack
// PURPOSE
//  Downstream of the ptfloat multiplier/adder: takes a normalised result {exp, man} and encodes it
//  into one DATA_W-bit ptfloat word {ew, exp[ew-1:0], man[M-1:0]} with M = DATA_W-EW_W-ew.
//  3-stage pipeline with start/done strobes; accepts one operand per cycle, no backpressure.
// PARAMETERS
//  DATA_W  32  packed ptfloat word width
//  EW_W    4   exponent-width field width; ew range 0..2^EW_W-1
// PORTS
//  clk_i     in   1               clock, rising edge
//  arst_n_i  in   1               asynchronous reset, active low
//  cke_i     in   1               clock enable; all stages hold when 0
//  start_i   in   1               operand valid strobe
//  exp_i     in   EXP_MAX_W+2     signed exponent from the arithmetic stage
//  man_i     in   RES_MAX_W       two's-complement fraction; man_i[top]^man_i[top-1]=1, or all zero
//  done_o    out  1               word_o valid strobe
//  word_o    out  DATA_W          packed ptfloat result
// BEHAVIOUR
//  - Reset: done_o=0, word_o=0, all pipeline registers 0. Reset mid-flight drops all in-flight data.
//  - Latency 3 cycles (cke_i=1): done_o = start_i delayed 3 enabled cycles; word_o held between strobes.
//  - Value = man_i (fraction in [-1,-0.5) U [0.5,1)) * 2^exp_i.
//  - S1: zero detect (man_i==0); exp class: exp_i>EXP_MAX -> OVF, exp_i<EXP_MIN -> UNF.
//    Leading-sign detect on exp_i -> ew = minimal signed width holding exp_i (exp 0 -> ew=0).
//  - S2: M = DATA_W-EW_W-ew; round man_i to M bits (see CONFIGURATION).
//    Rounding carry that flips the sign bit (0111..1 -> 1000..0): man=0100..0, exp+1, recompute ew;
//    0100..0 is exact at any M, so no second rounding. exp+1 > EXP_MAX -> OVF.
//  - S3: assemble: ew in bits [DATA_W-1-:EW_W], exp[ew-1:0] next, man[M-1:0] LSB-aligned.
//  - Boundaries: zero or UNF -> word 0. OVF -> ew=2^EW_W-1, exp=EXP_MAX, man = 011..1 (pos) / 100..0 (neg).
//  - Negative man exactly -0.5 (1100..0) is renormalised to -1.0 (100..0) with exp-1 in S1.
//  - Back-to-back start_i every cycle yields done_o every cycle; start_i=0 bubbles propagate.
// CONFIGURATION
//  PTFLOAT_PACK_RNE_EN defined: round-to-nearest-even using guard bit + sticky OR of lower bits.
//  Not defined: truncation (drop low bits, toward -inf); rounding-carry path removed.
// STRUCTURE
//  iob_ptfloat_defs.vh: EXP_MAX_W (=2^EW_W-1), MAN_MAX_W (=DATA_W-EW_W), RES_MAX_W (>=MAN_MAX_W+2),
//  EXP_MAX, EXP_MIN; shared with mul/add/unpack.
//  Sub-module iob_ptfloat_lsd: combinational leading-sign detector, exp -> ew; instanced in S1 and S2.
//  Pipeline registers via iob_reg (active-low async reset wrapper).
// TESTING (DATA_W=32, EW_W=4)
//  exp_i=0, man_i=0100..0 -> 3 cycles later done_o=1, word_o=0x04000000.
//  exp_i=1, man_i=0100..0 -> 0x25000000; exp_i=-1, same man -> 0x1A000000.
//  man_i=0, exp_i=any -> 0x00000000; exp_i<EXP_MIN -> 0x00000000.
//  exp_i=16384, man_i=0100..0 -> saturate 0xF7FFEFFF.
//  exp_i=0, man_i=0111..1 -> RNE_EN: 0x25000000; without: 0x07FFFFFF.
//  start_i every cycle with cke_i toggling, arst_n_i pulsed mid-stream -> done_o count/order match
//  enabled cycles; no done_o for operands issued before reset.

Source files
------------

// File: rtl/iob_ptfloat_pack_pkg.sv
// Shared definitions for the ptfloat packer: default geometry, exponent class and width helpers.
package iob_ptfloat_pack_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned EW_W_DEF   = 4;

    // Underflow and zero both encode to an all-zero word, so they share a class.
    typedef enum logic [1:0] {
        CLS_NORM = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_OVF  = 2'd2
    } exp_cls_e;

    // Widest exponent field: ew can reach 2^EW_W-1.
    function automatic int unsigned exp_max_w(input int unsigned ew_w);
        return (32'd1 << ew_w) - 32'd1;
    endfunction

    // Incoming fraction width: full mantissa field plus sign and one guard bit.
    function automatic int unsigned res_max_w(input int unsigned data_w, input int unsigned ew_w);
        return data_w - ew_w + 32'd2;
    endfunction

endpackage

// File: rtl/iob_ptfloat_pack_lsd.sv
// Leading-sign detector: minimal two's-complement width holding exp_i (0 maps to 0).
module iob_ptfloat_pack_lsd #(
    parameter int unsigned IN_W  = 18,
    parameter int unsigned OUT_W = 4
) (
    input  logic [IN_W-1:0]  exp_i,
    output logic [OUT_W-1:0] ew_o
);

    logic [IN_W-1:0] mag;
    int unsigned     n;

    // Highest bit differing from the sign, plus one for the sign itself.
    always_comb begin
        mag = exp_i[IN_W-1] ? ~exp_i : exp_i;
        n   = 0;
        for (int unsigned i = 0; i < IN_W; i++) begin
            if (mag[i]) n = i + 1;
        end
        ew_o = (exp_i == '0) ? '0 : OUT_W'(n + 1);
    end

endmodule

// File: rtl/iob_ptfloat_pack.sv
// ptfloat packer: {exp, man} -> {ew, exp[ew-1:0], man[M-1:0]}, 3-stage pipeline, no backpressure.
// Define PTFLOAT_PACK_RNE_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module iob_ptfloat_pack
    import iob_ptfloat_pack_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned EW_W   = EW_W_DEF
) (
    input  logic                                  clk_i,
    input  logic                                  arst_n_i,
    input  logic                                  cke_i,
    input  logic                                  start_i,
    input  logic [exp_max_w(EW_W)+1:0]            exp_i,
    input  logic [res_max_w(DATA_W, EW_W)-1:0]    man_i,
    output logic                                  done_o,
    output logic [DATA_W-1:0]                     word_o
);

    localparam int unsigned EXP_MAX_W = exp_max_w(EW_W);
    localparam int unsigned EXP_IW    = EXP_MAX_W + 2;
    localparam int unsigned EXP_XW    = EXP_IW + 1;
    localparam int unsigned MAN_MAX_W = DATA_W - EW_W;
    localparam int unsigned RES_MAX_W = res_max_w(DATA_W, EW_W);
    localparam int unsigned M_MIN     = MAN_MAX_W - EXP_MAX_W;
    localparam int unsigned SH_W      = $clog2(RES_MAX_W + 1);
    localparam int unsigned MW        = $clog2(MAN_MAX_W + 1);

    localparam logic [EXP_MAX_W-1:0]     EXP_MAX_F = EXP_MAX_W'((1 << (EXP_MAX_W - 1)) - 1);
    localparam logic signed [EXP_XW-1:0] EXP_MAX_X = EXP_XW'(EXP_MAX_F);
    localparam logic signed [EXP_XW-1:0] EXP_MIN_X = EXP_XW'(-(1 << (EXP_MAX_W - 1)));
    localparam logic [RES_MAX_W-1:0]     NEG_HALF  = {2'b11, {(RES_MAX_W - 2){1'b0}}};
    localparam logic [RES_MAX_W-1:0]     NEG_ONE   = {2'b10, {(RES_MAX_W - 2){1'b0}}};

    // Stage registers
    logic                        s1_vld_q, s1_vld_d;
    exp_cls_e                    s1_cls_q, s1_cls_d;
    logic signed [EXP_XW-1:0]    s1_exp_q, s1_exp_d;
    logic [EW_W-1:0]             s1_ew_q,  s1_ew_d;
    logic [RES_MAX_W-1:0]        s1_man_q, s1_man_d;

    logic                        s2_vld_q, s2_vld_d;
    exp_cls_e                    s2_cls_q, s2_cls_d;
    logic signed [EXP_XW-1:0]    s2_exp_q, s2_exp_d;
    logic [EW_W-1:0]             s2_ew_q,  s2_ew_d;
    logic [RES_MAX_W-1:0]        s2_man_q, s2_man_d;
    logic                        s2_neg_q, s2_neg_d;

    logic                        done_q, done_d;
    logic [DATA_W-1:0]           word_q, word_d;

    logic                        neg_half;

    // S1: renormalise -0.5, classify the exponent, size the exponent field.
    always_comb begin
        neg_half = (man_i == NEG_HALF);
        s1_vld_d = start_i;
        s1_man_d = neg_half ? NEG_ONE : man_i;
        s1_exp_d = {exp_i[EXP_IW-1], exp_i} - EXP_XW'(neg_half);
        if (man_i == '0)                 s1_cls_d = CLS_ZERO;
        else if (s1_exp_d > EXP_MAX_X)   s1_cls_d = CLS_OVF;
        else if (s1_exp_d < EXP_MIN_X)   s1_cls_d = CLS_ZERO;
        else                             s1_cls_d = CLS_NORM;
    end

    iob_ptfloat_pack_lsd #(.IN_W(EXP_XW), .OUT_W(EW_W)) u_lsd_s1 (
        .exp_i (s1_exp_d),
        .ew_o  (s1_ew_d)
    );

    // S2: drop the mantissa to M bits (arithmetic shift floors toward -inf).
    logic [MW-1:0]        m2;
    logic [SH_W-1:0]      sh;
    logic [RES_MAX_W-1:0] man_sh;

`ifdef PTFLOAT_PACK_RNE_EN
    logic signed [EXP_XW-1:0] exp_inc;
    logic [EW_W-1:0]          ew_inc;
    logic [MW-1:0]            m_inc;
    logic                     guard, sticky, rnd_up;
    logic [RES_MAX_W-1:0]     lo_mask;

    assign exp_inc = s1_exp_q + EXP_XW'(1);

    iob_ptfloat_pack_lsd #(.IN_W(EXP_XW), .OUT_W(EW_W)) u_lsd_s2 (
        .exp_i (exp_inc),
        .ew_o  (ew_inc)
    );
`endif

    always_comb begin
        m2       = MW'(MAN_MAX_W) - MW'(s1_ew_q);
        sh       = SH_W'(RES_MAX_W) - SH_W'(m2);
        man_sh   = RES_MAX_W'($signed(s1_man_q) >>> sh);
        s2_vld_d = s1_vld_q;
        s2_cls_d = s1_cls_q;
        s2_exp_d = s1_exp_q;
        s2_ew_d  = s1_ew_q;
        s2_man_d = man_sh;
        s2_neg_d = s1_man_q[RES_MAX_W-1];
`ifdef PTFLOAT_PACK_RNE_EN
        m_inc   = MW'(MAN_MAX_W) - MW'(ew_inc);
        guard   = s1_man_q[sh - SH_W'(1)];
        lo_mask = (RES_MAX_W'(1) << (sh - SH_W'(1))) - RES_MAX_W'(1);
        sticky  = |(s1_man_q & lo_mask);
        rnd_up  = guard & (sticky | man_sh[0]);
        // 0111..1 rounding up would flip the sign: renormalise to 0100..0 at the new width.
        if (rnd_up && (man_sh == ((RES_MAX_W'(1) << (m2 - MW'(1))) - RES_MAX_W'(1)))) begin
            s2_exp_d = exp_inc;
            s2_ew_d  = ew_inc;
            s2_man_d = RES_MAX_W'(1) << (m_inc - MW'(2));
            if ((s1_cls_q == CLS_NORM) && (exp_inc > EXP_MAX_X)) s2_cls_d = CLS_OVF;
        end else begin
            s2_man_d = man_sh + RES_MAX_W'(rnd_up);
        end
`endif
    end

    // S3: assemble the packed word, saturating on overflow.
    logic [MW-1:0]        m3;
    logic [EXP_XW-1:0]    exp_fld;
    logic [RES_MAX_W-1:0] man_fld;
    logic [DATA_W-1:0]    norm_word, ovf_word;

    always_comb begin
        m3        = MW'(MAN_MAX_W) - MW'(s2_ew_q);
        exp_fld   = s2_exp_q & ((EXP_XW'(1) << s2_ew_q) - EXP_XW'(1));
        man_fld   = s2_man_q & ((RES_MAX_W'(1) << m3) - RES_MAX_W'(1));
        norm_word = (DATA_W'(s2_ew_q) << (DATA_W - EW_W))
                  | (DATA_W'(exp_fld) << m3)
                  | DATA_W'(man_fld);
        ovf_word  = {{EW_W{1'b1}}, EXP_MAX_F,
                     s2_neg_q ? {1'b1, {(M_MIN - 1){1'b0}}} : {1'b0, {(M_MIN - 1){1'b1}}}};
        done_d    = s2_vld_q;
        word_d    = word_q;
        if (s2_vld_q) begin
            case (s2_cls_q)
                CLS_NORM: word_d = norm_word;
                CLS_OVF:  word_d = ovf_word;
                default:  word_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            s1_vld_q <= 1'b0;
            s1_cls_q <= CLS_NORM;
            s1_exp_q <= '0;
            s1_ew_q  <= '0;
            s1_man_q <= '0;
            s2_vld_q <= 1'b0;
            s2_cls_q <= CLS_NORM;
            s2_exp_q <= '0;
            s2_ew_q  <= '0;
            s2_man_q <= '0;
            s2_neg_q <= 1'b0;
            done_q   <= 1'b0;
            word_q   <= '0;
        end else if (cke_i) begin
            s1_vld_q <= s1_vld_d;
            s1_cls_q <= s1_cls_d;
            s1_exp_q <= s1_exp_d;
            s1_ew_q  <= s1_ew_d;
            s1_man_q <= s1_man_d;
            s2_vld_q <= s2_vld_d;
            s2_cls_q <= s2_cls_d;
            s2_exp_q <= s2_exp_d;
            s2_ew_q  <= s2_ew_d;
            s2_man_q <= s2_man_d;
            s2_neg_q <= s2_neg_d;
            done_q   <= done_d;
            word_q   <= word_d;
        end
    end

    assign done_o = done_q;
    assign word_o = word_q;

endmodule
